// File: rtl/adc_udp_framer_if.sv
// ---------------------------------------------------------------------------
// adc_udp_framer_if
//   Bundles the sample-side inputs and transmitter-side outputs of the ADC
//   UDP framer.
//
//   Signals
//     run          : acquisition enable
//     sample_valid : one-cycle qualifier for sample
//     sample       : ADC sample
//     tx_enable    : one-cycle start strobe to the transmitter ENABLE
//     tx_data      : payload held for the transmitter data input
//     overrun      : sticky flag, set on the first dropped sample
//     drop_count   : saturating count of dropped samples
//
//   Modports
//     master : sample source / observer (drives run, sample_valid, sample)
//     slave  : the framer itself
// ---------------------------------------------------------------------------
interface adc_udp_framer_if #(
    parameter int SAMPLE_W  = 12,
    parameter int PAYLOAD_W = 144
);
    logic                 run;
    logic                 sample_valid;
    logic [SAMPLE_W-1:0]  sample;
    logic                 tx_enable;
    logic [PAYLOAD_W-1:0] tx_data;
    logic                 overrun;
    logic [15:0]          drop_count;

    modport master (
        output run, sample_valid, sample,
        input  tx_enable, tx_data, overrun, drop_count
    );

    modport slave (
        input  run, sample_valid, sample,
        output tx_enable, tx_data, overrun, drop_count
    );
endinterface

// File: rtl/adc_udp_framer.sv
// ---------------------------------------------------------------------------
// adc_udp_framer
//   Packs 12-bit ADC samples into the 144-bit UDP payload for the 10BASE-T
//   transmitter and issues its one-cycle start strobe. Samples keep filling
//   a second frame while the previous one is on the wire; tx_data changes
//   only at launch so the transmitter can read payload bytes live.
//
//   Payload: {seq[3:0], frame_ovr, 7'b0, s0, s1, ... s10}, s0 at [131:120].
//
//   Ports
//     clk20 : 20 MHz clock, all logic on the rising edge
//     rst_n : synchronous active-low reset
//     bus   : adc_udp_framer_if.slave (run/sample_valid/sample in,
//             tx_enable/tx_data/overrun/drop_count out)
//
//   Configuration
//     FRAMER_TESTPATTERN_EN : when defined, accepted samples are replaced by a
//                             12-bit counter that advances per accepted sample.
// ---------------------------------------------------------------------------
module adc_udp_framer #(
    parameter int SAMPLE_W          = 12,
    parameter int SAMPLES_PER_FRAME = 11,
    parameter int HOLD_CYCLES       = 1400
) (
    input  logic            clk20,
    input  logic            rst_n,
    adc_udp_framer_if.slave bus
);
    localparam int FILL_W    = SAMPLE_W * SAMPLES_PER_FRAME;
    localparam int PAYLOAD_W = FILL_W + 12;
    localparam int CNT_W     = $clog2(SAMPLES_PER_FRAME + 1);
    localparam int HOLD_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0]  LAST_SLOT = CNT_W'(SAMPLES_PER_FRAME - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

    // FILL: collecting; READY: frame complete, waiting for holdoff;
    // LAUNCH: frame complete and holdoff expired, launches on this edge.
    typedef enum logic [1:0] {ST_FILL, ST_READY, ST_LAUNCH} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [FILL_W-1:0]    r_fill;
    logic [CNT_W-1:0]     r_count;
    logic [HOLD_W-1:0]    r_holdoff;
    logic [HOLD_W-1:0]    w_holdoff_next;
    logic [3:0]           r_seq;
    logic                 r_frame_ovr;
    logic                 r_tx_enable;
    logic [PAYLOAD_W-1:0] r_tx_data;
    logic                 r_overrun;
    logic [15:0]          r_drop_count;
    logic                 w_full;
    logic                 w_launch;
    logic                 w_accept;
    logic                 w_drop;
    logic [SAMPLE_W-1:0]  w_sample;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk20) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, whatever the statement order.
        if (!rst_n) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned,
        // which would otherwise infer a latch.
        w_state_next   = r_state;
        w_holdoff_next = r_holdoff;
        if (w_launch) begin
            w_holdoff_next = HOLD_LOAD;
        end else if (r_holdoff != '0) begin
            w_holdoff_next = r_holdoff - 1'b1;
        end

        unique case (r_state)
            ST_FILL: begin
                // Completing the frame: go straight to launch if the
                // holdoff will already be zero after this edge.
                if (w_accept && r_count == LAST_SLOT) begin
                    w_state_next = (w_holdoff_next == '0) ? ST_LAUNCH : ST_READY;
                end
            end
            ST_READY: begin
                if (!bus.run) begin
                    w_state_next = ST_FILL;
                end else if (w_holdoff_next == '0) begin
                    w_state_next = ST_LAUNCH;
                end
            end
            ST_LAUNCH: w_state_next = ST_FILL;
            default:   w_state_next = ST_FILL;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_full   = (r_state != ST_FILL);
        w_launch = (r_state == ST_LAUNCH);
        // The launch edge captures the old fill, so a sample arriving then
        // starts the next frame rather than being dropped.
        w_accept = bus.run && bus.sample_valid && (!w_full || w_launch);
        w_drop   = bus.run && bus.sample_valid && w_full && !w_launch;
    end

`ifdef FRAMER_TESTPATTERN_EN
    logic [SAMPLE_W-1:0] r_pattern;

    always_ff @(posedge clk20) begin
        if (!rst_n) begin
            r_pattern <= '0;
        end else if (w_accept) begin
            r_pattern <= r_pattern + 1'b1;
        end
    end

    assign w_sample = r_pattern;
`else
    assign w_sample = bus.sample;
`endif

    // ---------------- datapath and status ----------------
    always_ff @(posedge clk20) begin
        if (!rst_n) begin
            r_fill       <= '0;
            r_count      <= '0;
            r_holdoff    <= '0;
            r_seq        <= '0;
            r_frame_ovr  <= 1'b0;
            r_tx_enable  <= 1'b0;
            r_tx_data    <= '0;
            r_overrun    <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_holdoff   <= w_holdoff_next;
            r_tx_enable <= w_launch;

            if (w_accept) begin
                r_fill <= {r_fill[FILL_W-SAMPLE_W-1:0], w_sample};
            end

            // run=0 discards any frame in progress.
            if (!bus.run) begin
                r_count <= '0;
            end else if (w_launch) begin
                r_count <= w_accept ? CNT_W'(1) : '0;
            end else if (w_accept) begin
                r_count <= r_count + 1'b1;
            end

            if (w_launch) begin
                r_tx_data   <= {r_seq, r_frame_ovr, 7'b0, r_fill};
                r_seq       <= r_seq + 1'b1;
                r_frame_ovr <= 1'b0;
            end else if (w_drop) begin
                r_frame_ovr <= 1'b1;
            end

            if (w_drop) begin
                r_overrun <= 1'b1;
                if (r_drop_count != 16'hFFFF) begin
                    r_drop_count <= r_drop_count + 1'b1;
                end
            end
        end
    end

    assign bus.tx_enable  = r_tx_enable;
    assign bus.tx_data    = r_tx_data;
    assign bus.overrun    = r_overrun;
    assign bus.drop_count = r_drop_count;
endmodule

// File: doc/adc_udp_framer.md
# adc_udp_framer

Packs 12-bit ADC samples into the 144-bit UDP payload consumed by the 10BASE-T transmitter and issues its start strobe. The block sits directly upstream of the transmitter: it drives the transmitter's `ENABLE` and `data[143:0]` inputs. It double-buffers samples so acquisition continues while a frame is on the wire. It holds `tx_data` stable for the whole packet, because the transmitter reads payload bytes live during transmission.

## Interface
- `SAMPLE_W`, 12, ADC sample width; fixed by the payload layout.
- `SAMPLES_PER_FRAME`, 11, samples per payload; header (12 b) + 11×12 b = 144 b.
- `HOLD_CYCLES`, 1400, clk20 cycles after launch before the next launch is allowed (≥1168-cycle packet + pipeline + 192-cycle inter-frame gap).
- `clk20` in 1: 20 MHz system clock; all logic on its rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `run` in 1: acquisition enable.
- `sample_valid` in 1: one-cycle qualifier for `sample`.
- `sample` in 12: ADC sample.
- `tx_enable` out 1: one-cycle start strobe to the transmitter `ENABLE`.
- `tx_data` out 144: payload to the transmitter `data`.
- `overrun` out 1: sticky; set on the first dropped sample.
- `drop_count` out 16: count of dropped samples; saturates at 16'hFFFF.

## Operation
- **Fill register (132 b)** and fill count (0..11):
  - An accepted sample shifts in: fill <= {fill[119:0], sample}.
  - After 11 samples, the first sample sits at [131:120] and the last at [11:0].
- **Acceptance:** a sample is accepted when `run`=1, `sample_valid`=1 and `full`=0.
  - `full` sets on the cycle the 11th sample is accepted (count reaches 11).
- **Drop:** `run`=1, `sample_valid`=1 and `full`=1 drops the sample.
  - `overrun` <= 1.
  - `drop_count` increments (saturating).
  - `frame_ovr` <= 1.
- **`run`=0:**
  - Samples are ignored and are not counted as drops.
  - Fill count and `full` clear, discarding any partial frame.
  - An in-flight holdoff continues to completion.
- **Launch** occurs on a cycle where `full`=1 and holdoff=0. On that edge:
  - `tx_data` <= {seq[3:0], frame_ovr, 7'b0, fill[131:0]}.
  - `tx_enable` <= 1 for exactly one cycle.
  - holdoff <= HOLD_CYCLES.
  - seq increments (wraps 15→0).
  - frame_ovr, `full` and fill count clear.
- **Sample on the launch cycle:** a `sample_valid` arriving on the launch cycle is accepted into slot 0 of the new frame. Fill data is captured before the write, and the sample is not dropped.
- **Holdoff:** the counter decrements by 1 per cycle while nonzero. `tx_data` changes only at launch.
- **States:**
  - FILL: count<11.
  - READY: full, holdoff>0.
  - Launch: full, holdoff=0; the launch takes a single cycle and returns to FILL.
- The first frame after reset carries seq=0.

## Timing
- Reset values: `tx_enable`=0, `tx_data`=0, `overrun`=0, `drop_count`=0; seq, fill count, `full`, holdoff and frame_ovr are all 0.
- Launch latency:
  - If holdoff=0 when the 11th sample is accepted at edge N, `full`=1 after N and `tx_enable`=1 after edge N+1.
  - Otherwise `tx_enable`=1 one cycle after holdoff reaches 0.
- Launch spacing: two `tx_enable` pulses are separated by at least HOLD_CYCLES+1 cycles.
- Sustainable rate: 11 samples per 1401 cycles (≈157 kS/s) with no drops.
- Mid-operation reset (`rst_n`=0 for one edge): every register returns to its reset value on that edge. `tx_data` goes to 0 even if a packet is in flight.

## Configuration
- `FRAMER_TESTPATTERN_EN` defined:
  - Each accepted sample uses a 12-bit free-running pattern counter instead of `sample`.
  - The pattern counter resets to 0, increments per accepted sample, and wraps 4095→0.
  - Dropped samples do not advance it.
- Undefined: `sample` is used; no pattern counter is built.

## Test plan
- **Single frame:** reset, `run`=1, samples 0x001..0x00B one every 4 cycles.
  - One `tx_enable` pulse, one cycle after the 11th is accepted.
  - `tx_data` = {4'h0, 1'b0, 7'h00, 0x001,…,0x00B}.
- **Back-to-back:** 22 samples at 1 per cycle.
  - Second frame ready before holdoff expires.
  - Second pulse exactly 1401 cycles after the first, seq=1.
  - `tx_data` is unchanged between pulses.
- **Overrun:** 30 samples at 1 per cycle.
  - Samples 23–30 dropped; `drop_count`=8, `overrun`=1.
  - Second frame header bit 139 = 1.
- **Sample on launch cycle:** `sample_valid` with 0xABC on the launch cycle.
  - Not dropped; appears at [131:120] of the next frame.
- **run drop:** 5 samples, `run`=0 for 1 cycle, then 11 samples 0x100..0x10A.
  - Frame contains only 0x100..0x10A.
  - `drop_count`=0.
- **Seq wrap and reset:** 17 frames at low rate give seq 0..15, 0.
  - `rst_n`=0 mid-holdoff clears `tx_data` and holdoff.
  - The next frame launches with seq=0.
